// File: rtl/hsv2rgb.sv
// HSV (9-bit hue, 5-bit chroma, 5-bit value) to packed RGB555 converter, iterative datapath.
// Optional macro HSV2RGB_ROUND_EN: round-half-up divide instead of truncating divide.
module hsv2rgb #(
    parameter int HUE_WRAP = 360,
    parameter int SECTOR_W = 60
) (
    input  logic        clk,
    input  logic        res,
    input  logic        read,
    input  logic [8:0]  hue,
    input  logic [4:0]  saturation,
    input  logic [4:0]  value,
    input  logic        hue_invalid,
    output logic [15:0] data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRAP, S_SECTOR, S_MUL, S_DIV, S_PACK
    } state_t;

    localparam logic [10:0] HUE_W = 11'(HUE_WRAP);
    localparam logic [10:0] SEC_W = 11'(SECTOR_W);
    localparam logic [6:0]  DIV_D = 7'(SECTOR_W);
`ifdef HSV2RGB_ROUND_EN
    localparam logic [10:0] RND = 11'(SECTOR_W / 2);
`else
    localparam logic [10:0] RND = 11'd0;
`endif

    state_t      r_state;
    logic [8:0]  r_hue;
    logic [4:0]  r_s;
    logic [4:0]  r_v;
    logic        r_inv;
    logic [10:0] r_f;
    logic [2:0]  r_sector;
    logic [4:0]  r_mul_s;
    logic [10:0] r_p;
    logic [5:0]  r_rem;
    logic [3:0]  r_cnt;

    logic [4:0]  w_s_clamp;
    logic [4:0]  w_min;
    logic [10:0] w_p_sum;
    logic [6:0]  w_div_sh;
    logic        w_div_ge;
    logic [5:0]  w_div_rem;
    logic [4:0]  w_x;
    logic [4:0]  w_up;
    logic [4:0]  w_dn;
    logic [4:0]  w_r;
    logic [4:0]  w_g;
    logic [4:0]  w_b;

    assign w_s_clamp = (r_s > r_v) ? r_v : r_s;
    assign w_min     = r_v - r_s;
    assign w_p_sum   = r_p + (r_mul_s[0] ? r_f : 11'd0);
    assign w_div_sh  = {r_rem, r_p[10]};
    assign w_div_ge  = (w_div_sh >= DIV_D);
    assign w_div_rem = w_div_ge ? 6'(w_div_sh - DIV_D) : w_div_sh[5:0];
    // r_p holds the quotient by PACK; clamping to S' keeps min+x <= max
    assign w_x       = (r_p > {6'd0, r_s}) ? r_s : r_p[4:0];
    assign w_up      = w_min + w_x;
    assign w_dn      = r_v - w_x;

    always_comb begin
        w_r = r_v;
        w_g = w_up;
        w_b = w_min;
        case (r_sector)
            3'd1: begin w_r = w_dn;  w_g = r_v;   w_b = w_min; end
            3'd2: begin w_r = w_min; w_g = r_v;   w_b = w_up;  end
            3'd3: begin w_r = w_min; w_g = w_dn;  w_b = r_v;   end
            3'd4: begin w_r = w_up;  w_g = w_min; w_b = r_v;   end
            3'd5: begin w_r = r_v;   w_g = w_min; w_b = w_dn;  end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state  <= S_IDLE;
            r_hue    <= '0;
            r_s      <= '0;
            r_v      <= '0;
            r_inv    <= 1'b0;
            r_f      <= '0;
            r_sector <= '0;
            r_mul_s  <= '0;
            r_p      <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            data     <= 16'h0000;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (read) begin
                        r_hue   <= hue;
                        r_s     <= saturation;
                        r_v     <= value;
                        r_inv   <= hue_invalid;
                        busy    <= 1'b1;
                        r_state <= S_WRAP;
                    end
                end
                S_WRAP: begin
                    r_sector <= '0;
                    r_p      <= '0;
                    if (r_inv) begin
                        // zero chroma makes every component equal to V
                        r_s     <= '0;
                        r_state <= S_PACK;
                    end else begin
                        r_s     <= w_s_clamp;
                        r_f     <= ({2'b00, r_hue} >= HUE_W) ? {2'b00, r_hue} - HUE_W
                                                            : {2'b00, r_hue};
                        r_state <= S_SECTOR;
                    end
                end
                S_SECTOR: begin
                    if (r_f >= SEC_W) begin
                        r_f      <= r_f - SEC_W;
                        r_sector <= r_sector + 3'd1;
                    end else begin
                        r_mul_s <= r_s;
                        r_p     <= '0;
                        r_cnt   <= 4'd4;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_mul_s <= r_mul_s >> 1;
                    r_f     <= r_f << 1;
                    if (r_cnt == 4'd0) begin
                        r_p     <= w_p_sum + RND;
                        r_rem   <= '0;
                        r_cnt   <= 4'd10;
                        r_state <= S_DIV;
                    end else begin
                        r_p   <= w_p_sum;
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DIV: begin
                    r_rem <= w_div_rem;
                    r_p   <= {r_p[9:0], w_div_ge};
                    if (r_cnt == 4'd0)
                        r_state <= S_PACK;
                    else
                        r_cnt <= r_cnt - 4'd1;
                end
                S_PACK: begin
                    data    <= {1'b0, w_r, w_g, w_b};
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hsv2rgb.sv
// Self-checking bench for hsv2rgb: directed vector table, reset/handshake sequences, random vs reference model.
module tb_hsv2rgb;

    logic        clk = 1'b0;
    logic        res;
    logic        read;
    logic [8:0]  hue;
    logic [4:0]  saturation;
    logic [4:0]  value;
    logic        hue_invalid;
    logic [15:0] data;
    logic        busy;
    logic        done;

    int passed = 0;
    int total  = 0;

    hsv2rgb dut (
        .clk(clk), .res(res), .read(read), .hue(hue), .saturation(saturation),
        .value(value), .hue_invalid(hue_invalid), .data(data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

`ifdef HSV2RGB_ROUND_EN
    localparam int RND = 30;
`else
    localparam int RND = 0;
`endif

    typedef struct {
        int          h;
        int          s;
        int          v;
        int          inv;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] ref_rgb(input int h, input int s, input int v, input int inv);
        int sp, hh, sec, f, x, mx, mn, r, g, b;
        logic [4:0] r5, g5, b5;
        if (inv != 0) begin
            r = v; g = v; b = v;
        end else begin
            sp  = (s < v) ? s : v;
            hh  = (h >= 360) ? h - 360 : h;
            sec = hh / 60;
            f   = hh % 60;
            x   = (sp * f + RND) / 60;
            if (x > sp) x = sp;
            mx = v;
            mn = v - sp;
            case (sec)
                0: begin r = mx;     g = mn + x; b = mn;     end
                1: begin r = mx - x; g = mx;     b = mn;     end
                2: begin r = mn;     g = mx;     b = mn + x; end
                3: begin r = mn;     g = mx - x; b = mx;     end
                4: begin r = mn + x; g = mn;     b = mx;     end
                default: begin r = mx; g = mn;   b = mx - x; end
            endcase
        end
        r5 = 5'(r); g5 = 5'(g); b5 = 5'(b);
        return {1'b0, r5, g5, b5};
    endfunction

    function automatic int ref_lat(input int h, input int inv);
        int hh;
        if (inv != 0) return 2;
        hh = (h >= 360) ? h - 360 : h;
        return 19 + hh / 60;
    endfunction

    task automatic convert(input int h, input int s, input int v, input int inv,
                           output logic [15:0] d, output int lat);
        @(negedge clk);
        hue = 9'(h); saturation = 5'(s); value = 5'(v); hue_invalid = 1'(inv);
        read = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
        chk("busy_after_capture", busy, 1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_seen", done, 1);
        d = data;
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
    endtask

    task automatic run_case(input string name, input int h, input int s, input int v,
                            input int inv, input logic [15:0] exp, input int exp_lat);
        logic [15:0] d;
        int lat;
        convert(h, s, v, inv, d, lat);
        if (d !== exp || lat != exp_lat)
            $display("  case %s: hue=%0d s=%0d v=%0d inv=%0d", name, h, s, v, inv);
        chk({name, "_data"}, d, exp);
        chk({name, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        logic [15:0] d;
        int lat, n, extra, ah, as_, av;

        vecs[0] = '{0,   31, 31, 0, 16'h7C00, 19};
        vecs[1] = '{120, 31, 31, 0, 16'h03E0, 21};
        vecs[2] = '{90,  20, 30, 0, 16'h53CA, 20};
        vecs[3] = '{480, 31, 31, 0, 16'h03E0, 21};
        vecs[4] = '{50,  31, 31, 0, (RND != 0) ? 16'h7F40 : 16'h7F20, 19};
        vecs[5] = '{0,   5,  17, 1, 16'h4631, 2};
        vecs[6] = '{0,   31, 10, 0, 16'h2800, 19};
        vecs[7] = '{511, 31, 31, 0, 16'h03F0, 21};
        vecs[8] = '{359, 31, 31, 0, 16'h7C01, 24};
        vecs[9] = '{360, 31, 31, 0, 16'h7C00, 19};

        res = 1'b1; read = 1'b0; hue = '0; saturation = '0; value = '0; hue_invalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", data, 16'h0000);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        @(negedge clk);
        res = 1'b0;

        for (int i = 0; i < 10; i++)
            run_case($sformatf("vec%0d", i), vecs[i].h, vecs[i].s, vecs[i].v,
                     vecs[i].inv, vecs[i].exp, vecs[i].lat);

        // asynchronous reset in the middle of the divide
        @(negedge clk);
        hue = 9'd200; saturation = 5'd31; value = 5'd31; hue_invalid = 1'b0; read = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        res = 1'b1;
        #1;
        chk("midreset_data", data, 16'h0000);
        chk("midreset_done", done, 0);
        chk("midreset_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        res = 1'b0;
        run_case("after_reset", 200, 31, 31, 0, 16'h02BF, 22);

        // read held high with inputs churning while busy
        ah = 300; as_ = 25; av = 28;
        @(negedge clk);
        hue = 9'(ah); saturation = 5'(as_); value = 5'(av); hue_invalid = 1'b0; read = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!done && n < 40) begin
            hue = 9'($urandom_range(0, 511));
            saturation = 5'($urandom_range(0, 31));
            value = 5'($urandom_range(0, 31));
            hue_invalid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        read = 1'b0;
        chk("held_done_seen", done, 1);
        chk("held_data", data, ref_rgb(ah, as_, av, 0));
        chk("held_latency", n, ref_lat(ah, 0));
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("held_no_queued", extra, 0);

        for (int i = 0; i < 40; i++) begin
            int h, s, v, inv;
            h = $urandom_range(0, 511);
            s = $urandom_range(0, 31);
            v = $urandom_range(0, 31);
            inv = ($urandom_range(0, 7) == 0) ? 1 : 0;
            run_case($sformatf("rand%0d", i), h, s, v, inv, ref_rgb(h, s, v, inv), ref_lat(h, inv));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
